// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// the parity rule used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int         OVERSAMPLE  = 16;
   localparam logic [3:0] MID_SAMPLE  = 4'd7;
   localparam logic [3:0] LAST_SAMPLE = 4'd15;

   typedef enum logic {
      PARITY_EVEN = 1'b0,
      PARITY_ODD  = 1'b1
   } parity_mode_e;

   localparam parity_mode_e PARITY_MODE = PARITY_EVEN;

   // 1 when the received parity bit disagrees with the data under the given mode
   function automatic logic parity_bad(input logic [7:0] data, input logic par,
                                       input parity_mode_e mode);
      return par ^ (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side receive buffer port: byte, error flags and valid/ready handshake.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;

   modport master (output rx_data, rx_valid, parity_err, frame_err, overrun_err,
                   input  rx_ready);
   modport slave  (input  rx_data, rx_valid, parity_err, frame_err, overrun_err,
                   output rx_ready);
endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, with a
// synchronous clear used to phase-align sampling to a start edge.
module uart_rx_tick_gen #(
   parameter int CLK_DIV = 33
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clr || tick) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8E1 frames, 16x oversampling with mid-bit sampling, and a
// one-entry receive buffer handed to the host over a valid/ready handshake.
module uart_rx #(
   parameter int CLK_DIV    = 33,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       UARTn_RXD,
   output logic       UARTn_RTS,
   uart_rx_if.master  host
);
   import uart_pkg::*;

   localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

   logic        rxd_p0, rxd_p1, rxd_prev;
   logic        rxd_s;
   logic        start_edge, tick;
   uart_state_e state;
   logic [3:0]  s_cnt;
   logic [2:0]  b_idx;
   logic [7:0]  shift;
   logic        par_bad, stop_sample;
   logic        load_p1;

   assign rxd_s      = rxd_p1;
   assign start_edge = (state == IDLE) && !rxd_s && rxd_prev;

   uart_rx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_edge),
      .tick (tick)
   );

   // Bit-level receive FSM; data-path registers (shift, par_bad, stop_sample) carry no reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_p0   <= 1'b1;
         rxd_p1   <= 1'b1;
         rxd_prev <= 1'b1;
         state    <= IDLE;
         s_cnt    <= '0;
         b_idx    <= '0;
         load_p1  <= 1'b0;
      end else begin
         rxd_p0   <= UARTn_RXD;
         rxd_p1   <= rxd_p0;
         rxd_prev <= rxd_p1;
         load_p1  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  state <= START;
                  s_cnt <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (s_cnt == MID_TICK) begin
                     if (rxd_s) begin
                        state <= IDLE;
                     end else begin
                        s_cnt <= '0;
                        b_idx <= '0;
                        state <= DATA;
                     end
                  end else begin
                     s_cnt <= s_cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  s_cnt <= s_cnt + 4'd1;
                  if (s_cnt == LAST_TICK) begin
                     shift[b_idx] <= rxd_s;
                     if (b_idx == 3'd7) state <= PARITY;
                     else               b_idx <= b_idx + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  s_cnt <= s_cnt + 4'd1;
                  if (s_cnt == LAST_TICK) begin
                     par_bad <= parity_bad(shift, rxd_s, PARITY_MODE);
                     state   <= STOP;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  s_cnt <= s_cnt + 4'd1;
                  if (s_cnt == LAST_TICK) begin
                     stop_sample <= rxd_s;
                     load_p1     <= 1'b1;
                     state       <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Receive buffer stage: load one clock after the stop sample, or flag overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         host.rx_data     <= '0;
         host.rx_valid    <= 1'b0;
         host.parity_err  <= 1'b0;
         host.frame_err   <= 1'b0;
         host.overrun_err <= 1'b0;
         UARTn_RTS        <= 1'b1;
      end else begin
         if (host.rx_valid && host.rx_ready) begin
            host.rx_valid    <= 1'b0;
            host.overrun_err <= 1'b0;
         end
         if (load_p1) begin
            if (!host.rx_valid || host.rx_ready) begin
               host.rx_data    <= shift;
               host.parity_err <= par_bad;
               host.frame_err  <= ~stop_sample;
               host.rx_valid   <= 1'b1;
            end else begin
               host.overrun_err <= 1'b1;
            end
         end
         UARTn_RTS <= ~host.rx_valid;
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic,
// compared every cycle against a frame-level model of the receive buffer.
module tb_uart_rx;
   localparam int CLK_DIV = 4;
   localparam int BIT_CLK = 16 * CLK_DIV;
   // 3 clk sync/edge detect, 8 ticks to mid start bit, 16 ticks per bit through stop, 1 clk load
   localparam int LOAD_LAT = 3 + CLK_DIV * (8 + 16 * 10) + 1;

   typedef struct {
      int         load_cyc;
      logic [7:0] data;
      logic       pbad;
      logic       ferr;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rxd;
   logic rts;

   uart_rx_if bus ();

   uart_rx #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .UARTn_RXD (rxd),
      .UARTn_RTS (rts),
      .host      (bus)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   bit         started = 0;
   bit         done = 0;
   bit         rnd_done = 0;
   exp_t       exp_q[$];
   logic       m_valid, m_rts, m_pe, m_fe, m_ov;
   logic [7:0] m_data;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Receive-buffer semantics, advanced once per clock edge
   task automatic model_step();
      cyc++;
      if (rst) begin
         started = 1;
         m_valid = 0; m_data = 0; m_pe = 0; m_fe = 0; m_ov = 0; m_rts = 1;
         exp_q.delete();
      end else begin
         m_rts = !m_valid;
         if (m_valid && bus.rx_ready) begin
            m_valid = 0;
            m_ov    = 0;
         end
         if (exp_q.size() > 0 && exp_q[0].load_cyc == cyc) begin
            if (!m_valid) begin
               m_valid = 1;
               m_data  = exp_q[0].data;
               m_pe    = exp_q[0].pbad;
               m_fe    = exp_q[0].ferr;
            end else begin
               m_ov = 1;
            end
            void'(exp_q.pop_front());
         end
      end
   endtask

   task automatic compare_all();
      chk("rx_valid", {7'd0, bus.rx_valid}, {7'd0, m_valid});
      chk("rx_data", bus.rx_data, m_data);
      chk("parity_err", {7'd0, bus.parity_err}, {7'd0, m_pe});
      chk("frame_err", {7'd0, bus.frame_err}, {7'd0, m_fe});
      chk("overrun_err", {7'd0, bus.overrun_err}, {7'd0, m_ov});
      chk("UARTn_RTS", {7'd0, rts}, {7'd0, m_rts});
   endtask

   // Drives one frame starting just after a clock edge; the stop level is left on the line
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input bit pin_timing);
      exp_t e;
      int   k;
      k          = cyc;
      e.load_cyc = k + LOAD_LAT;
      e.data     = d;
      e.pbad     = (par != ^d);
      e.ferr     = !stop;
      exp_q.push_back(e);
      rxd = 1'b0;
      wait_cyc(BIT_CLK);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         wait_cyc(BIT_CLK);
      end
      rxd = par;
      wait_cyc(BIT_CLK);
      rxd = stop;
      if (pin_timing) begin
         wait_until(k + LOAD_LAT - 1);
         chk("valid_before_load", {7'd0, bus.rx_valid}, 8'h00);
         wait_cyc(1);
         chk("valid_at_load", {7'd0, bus.rx_valid}, 8'h01);
         chk("rts_at_load", {7'd0, rts}, 8'h01);
         wait_cyc(1);
         chk("rts_after_load", {7'd0, rts}, 8'h00);
      end
      wait_until(k + 11 * BIT_CLK);
   endtask

   task automatic consume();
      bus.rx_ready = 1'b1;
      wait_cyc(1);
      bus.rx_ready = 1'b0;
      wait_cyc(1);
   endtask

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      bus.rx_ready = 1'b0;
      fork
         while (!done) begin
            @(posedge clk);
            model_step();
         end
         while (!done) begin
            @(negedge clk);
            if (started) compare_all();
         end
         begin
            wait_cyc(4);
            chk("reset_valid", {7'd0, bus.rx_valid}, 8'h00);
            chk("reset_rts", {7'd0, rts}, 8'h01);
            chk("reset_data", bus.rx_data, 8'h00);
            rst = 1'b0;
            wait_cyc(10);

            // Clean 0x2A with latency pinned
            send_frame(8'h2A, 1'b1, 1'b1, 1);
            rxd = 1'b1;
            wait_cyc(5);
            chk("clean_data", bus.rx_data, 8'h2A);
            chk("clean_perr", {7'd0, bus.parity_err}, 8'h00);
            chk("clean_ferr", {7'd0, bus.frame_err}, 8'h00);
            consume();
            chk("consumed_valid", {7'd0, bus.rx_valid}, 8'h00);
            chk("consumed_rts", {7'd0, rts}, 8'h01);

            // Bad parity
            send_frame(8'h2A, 1'b0, 1'b1, 0);
            rxd = 1'b1;
            wait_cyc(5);
            chk("badpar_data", bus.rx_data, 8'h2A);
            chk("badpar_perr", {7'd0, bus.parity_err}, 8'h01);
            chk("badpar_ferr", {7'd0, bus.frame_err}, 8'h00);
            consume();

            // Bad stop bit followed by a break
            send_frame(8'h55, 1'b0, 1'b0, 0);
            wait_cyc(3 * BIT_CLK);
            chk("break_valid", {7'd0, bus.rx_valid}, 8'h01);
            chk("break_ferr", {7'd0, bus.frame_err}, 8'h01);
            chk("break_data", bus.rx_data, 8'h55);
            rxd = 1'b1;
            wait_cyc(10);
            consume();
            wait_cyc(12 * BIT_CLK);

            // Glitch shorter than half a bit
            rxd = 1'b0;
            wait_cyc(20);
            rxd = 1'b1;
            wait_cyc(12 * BIT_CLK);
            chk("glitch_valid", {7'd0, bus.rx_valid}, 8'h00);

            // Back-to-back with the buffer still full
            send_frame(8'h01, 1'b1, 1'b1, 0);
            send_frame(8'hFF, 1'b0, 1'b1, 0);
            rxd = 1'b1;
            wait_cyc(5);
            chk("ovr_data", bus.rx_data, 8'h01);
            chk("ovr_flag", {7'd0, bus.overrun_err}, 8'h01);
            consume();
            chk("ovr_cleared", {7'd0, bus.overrun_err}, 8'h00);

            // Back-to-back with a consume exactly on the second load
            send_frame(8'h01, 1'b1, 1'b1, 0);
            fork
               send_frame(8'hFF, 1'b0, 1'b1, 0);
               begin
                  wait_until(cyc + LOAD_LAT - 1);
                  bus.rx_ready = 1'b1;
                  wait_cyc(1);
                  bus.rx_ready = 1'b0;
               end
            join
            rxd = 1'b1;
            wait_cyc(5);
            chk("swap_data", bus.rx_data, 8'hFF);
            chk("swap_ovr", {7'd0, bus.overrun_err}, 8'h00);
            chk("swap_valid", {7'd0, bus.rx_valid}, 8'h01);

            // Reset in the middle of 0xA5's data bits
            rxd = 1'b0;
            wait_cyc(BIT_CLK);
            for (int i = 0; i < 3; i++) begin
               rxd = (8'hA5 >> i) & 8'h01;
               wait_cyc(BIT_CLK);
            end
            rst = 1'b1;
            rxd = 1'b1;
            wait_cyc(1);
            chk("midrst_valid", {7'd0, bus.rx_valid}, 8'h00);
            chk("midrst_data", bus.rx_data, 8'h00);
            chk("midrst_rts", {7'd0, rts}, 8'h01);
            wait_cyc(3);
            rst = 1'b0;
            wait_cyc(20);
            send_frame(8'h3C, 1'b0, 1'b1, 0);
            rxd = 1'b1;
            wait_cyc(5);
            chk("post_rst_data", bus.rx_data, 8'h3C);
            chk("post_rst_perr", {7'd0, bus.parity_err}, 8'h00);
            consume();

            // Randomized traffic with a sparse random host
            fork
               begin
                  for (int f = 0; f < 24; f++) begin
                     logic [7:0] d;
                     logic       par, stop;
                     int         gap;
                     d    = 8'($urandom);
                     par  = (^d) ^ ($urandom_range(0, 3) == 0);
                     stop = ($urandom_range(0, 4) != 0);
                     gap  = stop ? $urandom_range(0, 40) : $urandom_range(3, 40);
                     send_frame(d, par, stop, 0);
                     rxd = 1'b1;
                     wait_cyc(gap);
                  end
                  wait_cyc(20);
                  rnd_done = 1;
               end
               while (!rnd_done) begin
                  bus.rx_ready = ($urandom_range(0, 199) == 0);
                  wait_cyc(1);
               end
            join
            bus.rx_ready = 1'b0;
            wait_cyc(5);
            done = 1;
         end
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
